// File: rtl/wb_host_initiator.sv
// Wishbone classic initiator: one single-beat bus cycle per local command,
// with an ack timeout, a response holding register and transaction/error counters.
module wb_host_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic [CNT_W-1:0] txn_count,
    output logic [7:0]       err_count
);

    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic [7:0]         err_q, err_d;

    // Next-state and output decode; every handshake-facing output is registered
    // from the upcoming state so it is glitch-free and reset-clean.
    always_comb begin
        state_d = state_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        we_d = we_q;
        sel_d = sel_q;
        adr_d = adr_q;
        dat_d = dat_q;
        tmo_d = tmo_q;
        txn_d = txn_q;
        err_d = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0000_0000 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (TMO_EN && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                    rsp_dat_d = 32'h0000_0000;
                    rsp_err_d = 1'b1;
                    err_d     = (err_q == 8'hFF) ? 8'hFF : (err_q + 8'd1);
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    txn_d   = txn_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        cyc_d       = (state_d == BUS);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0000_0000;
            dat_q       <= 32'h0000_0000;
            tmo_q       <= {TMO_W{1'b0}};
            txn_q       <= {CNT_W{1'b0}};
            err_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            tmo_q       <= tmo_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

endmodule

// File: doc/wb_host_initiator.md
# wb_host_initiator

Wishbone classic initiator: turns single-beat commands from a local valid/ready port into Wishbone bus cycles and returns one response per command. It is the host side of the Wishbone slave port on the user project. It drives the management-style Wishbone signals toward a target so the target can be exercised on-chip or in a testbench. It also enforces a bus timeout and keeps transaction and error statistics.

## Interface
Parameters:
- TIMEOUT, 255: number of bus cycles to wait for ack before aborting; 0 disables the timeout.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_ni  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid && ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte enables.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid && ready.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle and strobe, always driven equal.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from the target.
- wbm_ack_i  in  1  target acknowledge.
- txn_count  out  CNT_W  completed transactions, including errors; wraps modulo 2^CNT_W.
- err_count  out  8  timeout count; saturates at 255.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On handshake: latch we/sel/adr/dat into the wbm_* output registers, clear the timeout counter, go to BUS.
- **BUS**
  - wbm_cyc_o = wbm_stb_o = 1.
  - wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o are held stable.
  - On wbm_ack_i = 1: rsp_dat = wbm_dat_i for a read or 0 for a write; rsp_err = 0; go to RESP.
  - Otherwise the counter increments. When TIMEOUT != 0 and the counter == TIMEOUT-1 with no ack: rsp_dat = 0, rsp_err = 1, err_count += 1 (saturating), go to RESP.
  - Ack wins over a timeout in the same cycle.
- **RESP**
  - rsp_valid = 1; rsp_dat and rsp_err are held stable.
  - On rsp_ready: txn_count += 1, go to IDLE.
- wbm_ack_i is ignored outside BUS; a stray ack must not change state or outputs.
- wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values outside BUS. Only cyc/stb qualify them.
- Exactly one bus cycle per command. No pipelining, no bursts, no retries.

## Timing
- Reset values: cmd_ready = 0 during reset and 1 in the first cycle after reset. All other outputs are 0: rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, txn_count, err_count. State = IDLE.
- Command accepted at edge N: cyc/stb are high in cycle N+1.
- Ack high in cycle N+k (k ≥ 1): cyc/stb are low and rsp_valid is high in cycle N+k+1. Minimum command-to-response latency is 2 cycles.
- Timeout: cyc/stb are high for exactly TIMEOUT cycles, then rsp_valid with rsp_err = 1 in the next cycle.
- rsp_ready high in the first RESP cycle: cmd_ready is high the following cycle. The minimum issue interval is 3 cycles.
- Reset asserted in any state: at the next edge all outputs take their reset values, cyc/stb drop, and any pending response is discarded without counting.

## Test plan
- **Read:** cmd read adr = 0x3000_0004, sel = 0xF; target acks on the first BUS cycle with 0xDEAD_BEEF -> cyc high for exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_dat = 0xDEAD_BEEF, rsp_err = 0; txn_count = 1.
- **Write with wait states:** cmd write adr = 0x3000_0000, dat = 0x1234_5678, sel = 0x3; ack after 3 wait cycles -> wbm_we_o = 1, adr/dat/sel stable for all 4 BUS cycles; rsp_dat = 0, rsp_err = 0.
- **Timeout:** TIMEOUT = 4, no ack -> cyc high for exactly 4 cycles; rsp_err = 1, rsp_dat = 0, err_count = 1. Ack on the 4th cycle instead -> rsp_err = 0, err_count unchanged.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles after a response -> rsp_valid, rsp_dat and rsp_err stable; cmd_ready = 0; a stray ack has no effect. Release -> cmd_ready = 1 next cycle.
- **Reset mid-BUS:** drive wb_rst_ni = 0 while cyc = 1 -> cyc/stb = 0 and rsp_valid = 0 after that edge; txn_count = 0; a new read after reset completes normally.
- **Counters:** 300 forced timeouts -> err_count = 255 (saturated); CNT_W = 4 with 17 commands -> txn_count = 1 (wrapped).
